// File: rtl/frame_buffer_ctrl.sv
// Single-port RAM frame buffer: fills DEPTH words from an upstream stream,
// then drains them in address order downstream, alternating strictly.
module frame_buffer_ctrl #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 256,
    localparam int unsigned ADDR_BW = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [WIDTH-1:0]   data_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic [WIDTH-1:0]   data_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               last_o,
    output logic               mem_en_o,
    output logic               mem_wr_en_o,
    output logic [ADDR_BW-1:0] mem_addr_o,
    output logic [WIDTH-1:0]   mem_data_o,
    input  logic [WIDTH-1:0]   mem_data_i
);

    localparam logic [ADDR_BW-1:0] LAST_ADDR = ADDR_BW'(DEPTH - 1);

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_BW-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BW-1:0] rd_ptr_q, rd_ptr_d;
    logic               rd_done_q, rd_done_d;
    logic               rd_valid_q, rd_valid_d;
    logic               rd_last_q, rd_last_d;

    logic wr_fire_c;
    logic rd_issue_c;
    logic out_hs_c;

    // RAM accesses are suppressed while reset is asserted so nothing is written mid-reset.
    assign wr_fire_c  = (state_q == ST_FILL) && valid_i && !rst_i;
    assign rd_issue_c = (state_q == ST_DRAIN) && !rd_done_q && (!rd_valid_q || ready_i) && !rst_i;
    assign out_hs_c   = rd_valid_q && ready_i;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_FILL;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_done_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_done_q  <= rd_done_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
        end
    end

    // Next-state and pointer update
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_done_d  = rd_done_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;

        if (state_q == ST_FILL) begin
            if (wr_fire_c) begin
                wr_ptr_d = wr_ptr_q + ADDR_BW'(1);
                if (wr_ptr_q == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                end
            end
        end else begin
            // A new read replaces the presented word at the same edge that hands it off.
            if (rd_issue_c) begin
                rd_ptr_d   = rd_ptr_q + ADDR_BW'(1);
                rd_done_d  = (rd_ptr_q == LAST_ADDR);
                rd_valid_d = 1'b1;
                rd_last_d  = (rd_ptr_q == LAST_ADDR);
            end else if (out_hs_c) begin
                rd_valid_d = 1'b0;
                rd_last_d  = 1'b0;
                if (rd_last_q) begin
                    state_d   = ST_FILL;
                    rd_ptr_d  = '0;
                    rd_done_d = 1'b0;
                end
            end
        end
    end

    // Outputs; the RAM holds its read data while disabled, so data_o is stable under stall.
    always_comb begin
        ready_o     = (state_q == ST_FILL);
        valid_o     = rd_valid_q;
        last_o      = rd_valid_q && rd_last_q;
        data_o      = mem_data_i;
        mem_en_o    = wr_fire_c || rd_issue_c;
        mem_wr_en_o = wr_fire_c;
        mem_addr_o  = (state_q == ST_FILL) ? wr_ptr_q : rd_ptr_q;
        mem_data_o  = data_i;
    end

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Bench for frame_buffer_ctrl with DEPTH=4 and a behavioural single-port RAM;
// a queue scoreboard checks every downstream word and its last flag.
module tb_frame_buffer_ctrl;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned ABW   = 2;

    logic             clk_i;
    logic             rst_i;
    logic [WIDTH-1:0] data_i;
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] data_o;
    logic             valid_o;
    logic             ready_i;
    logic             last_o;
    logic             mem_en_o;
    logic             mem_wr_en_o;
    logic [ABW-1:0]   mem_addr_o;
    logic [WIDTH-1:0] mem_data_o;
    logic [WIDTH-1:0] mem_data_i;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             l;
    } exp_t;

    exp_t exp_q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   out_cnt  = 0;
    int   fill_cnt = 0;

    logic [WIDTH-1:0] ram [DEPTH];

    frame_buffer_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .last_o      (last_o),
        .mem_en_o    (mem_en_o),
        .mem_wr_en_o (mem_wr_en_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Single-port RAM with registered read that holds its output when disabled
    always @(posedge clk_i) begin
        if (mem_en_o) begin
            if (mem_wr_en_o) ram[mem_addr_o] <= mem_data_o;
            else             mem_data_i <= ram[mem_addr_o];
        end
    end

    // Scoreboard: push accepted upstream words, pop on downstream handshakes
    always @(negedge clk_i) begin
        if (rst_i) begin
            exp_q.delete();
            fill_cnt = 0;
        end else begin
            chk_cnt++;
            if ((mem_wr_en_o && !mem_en_o) || (valid_o && ready_o) || (last_o && !valid_o))
                $display("FAIL invariant: wr_en=%b en=%b valid_o=%b ready_o=%b last_o=%b",
                         mem_wr_en_o, mem_en_o, valid_o, ready_o, last_o);
            else pass_cnt++;
            if (valid_i && ready_o) begin
                exp_q.push_back('{d: data_i, l: (fill_cnt == DEPTH - 1)});
                fill_cnt = (fill_cnt + 1) % DEPTH;
            end
            if (valid_o && ready_i) begin
                exp_t e;
                out_cnt++;
                chk_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_underflow: got data %h last %b, expected no output", data_o, last_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({data_o, last_o} !== {e.d, e.l})
                        $display("FAIL sb_word: got %h/%b expected %h/%b", data_o, last_o, e.d, e.l);
                    else pass_cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic fill_frame(input logic [WIDTH-1:0] base);
        int n = 0;
        for (int g = 0; g < 50 && n < DEPTH; g++) begin
            data_i  = base + WIDTH'(n);
            valid_i = 1'b1;
            #1;
            if (ready_o) n++;
            tick();
        end
        valid_i = 1'b0;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (ready_o) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; valid_i = 1'b1; ready_i = 1'b0; data_i = 32'h1234_5678;
        repeat (2) tick();
        #1;
        chk_cnt++;
        if ({ready_o, valid_o, last_o, mem_en_o, mem_wr_en_o} !== 5'b10000)
            $display("FAIL reset_outputs: got %b expected 10000",
                     {ready_o, valid_o, last_o, mem_en_o, mem_wr_en_o});
        else pass_cnt++;
        rst_i = 1'b0; valid_i = 1'b0;
        tick();
    endtask

    task automatic test_fill_drain();
        int base = out_cnt;
        ready_i = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            data_i = 32'hA + WIDTH'(i); valid_i = 1'b1;
            #1;
            chk_cnt++;
            if ({mem_en_o, mem_wr_en_o, mem_addr_o, mem_data_o} !== {2'b11, ABW'(i), 32'hA + WIDTH'(i)})
                $display("FAIL fill_write: got en/we %b%b addr %0d data %h expected 11 addr %0d",
                         mem_en_o, mem_wr_en_o, mem_addr_o, mem_data_o, i);
            else pass_cnt++;
            tick();
        end
        valid_i = 1'b0;
        #1;
        chk_cnt++;
        if ({mem_en_o, mem_wr_en_o, mem_addr_o, valid_o, ready_o} !== 6'b10_00_00)
            $display("FAIL first_read: got %b expected 100000",
                     {mem_en_o, mem_wr_en_o, mem_addr_o, valid_o, ready_o});
        else pass_cnt++;
        tick();
        for (int k = 0; k < DEPTH; k++) begin
            #1;
            chk_cnt++;
            if ({valid_o, data_o, last_o} !== {1'b1, 32'hA + WIDTH'(k), k == DEPTH - 1})
                $display("FAIL drain_word%0d: got v=%b d=%h l=%b expected v=1 d=%h", k,
                         valid_o, data_o, last_o, 32'hA + WIDTH'(k));
            else pass_cnt++;
            tick();
        end
        #1;
        chk_cnt++;
        if ({ready_o, valid_o, out_cnt - base} !== {2'b10, 32'(DEPTH)})
            $display("FAIL after_drain: got ready=%b valid=%b words=%0d expected 1 0 %0d",
                     ready_o, valid_o, out_cnt - base, DEPTH);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_backpressure();
        int base = out_cnt;
        bit ok;
        ready_i = 1'b1;
        fill_frame(32'hA);
        tick();
        tick();
        ready_i = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk_cnt++;
            if ({valid_o, data_o, mem_en_o} !== {1'b1, 32'hB, 1'b0})
                $display("FAIL stall_hold%0d: got v=%b d=%h en=%b expected v=1 d=b en=0",
                         s, valid_o, data_o, mem_en_o);
            else pass_cnt++;
            tick();
        end
        ready_i = 1'b1;
        wait_ready(ok);
        chk_cnt++;
        if (!ok || (out_cnt - base) != DEPTH)
            $display("FAIL bp_count: got ready=%b words=%0d expected 1 %0d", ok, out_cnt - base, DEPTH);
        else pass_cnt++;
    endtask

    task automatic test_upstream_gaps();
        int base = out_cnt;
        bit ok;
        ready_i = 1'b1;
        for (int c = 0; c < 2 * DEPTH; c++) begin
            valid_i = (c % 2 == 0);
            data_i  = valid_i ? 32'h10 + WIDTH'(c / 2) : 32'hDEAD_BEEF;
            #1;
            chk_cnt++;
            if (mem_wr_en_o !== valid_i || (valid_i && mem_addr_o !== ABW'(c / 2)))
                $display("FAIL gap_write%0d: got we=%b addr=%0d expected we=%b addr=%0d",
                         c, mem_wr_en_o, mem_addr_o, valid_i, c / 2);
            else pass_cnt++;
            tick();
        end
        valid_i = 1'b0;
        wait_ready(ok);
        chk_cnt++;
        if (!ok || (out_cnt - base) != DEPTH)
            $display("FAIL gap_count: got ready=%b words=%0d expected 1 %0d", ok, out_cnt - base, DEPTH);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int base = out_cnt;
        int idx = 0;
        int stall = 0;
        bit ok;
        ready_i = 1'b1;
        for (int c = 0; c < 30; c++) begin
            valid_i = (idx < 2 * DEPTH);
            data_i  = WIDTH'(idx + 1);
            #1;
            if (valid_i && ready_o) idx++;
            else if (valid_i) stall++;
            tick();
        end
        valid_i = 1'b0;
        wait_ready(ok);
        chk_cnt++;
        if (stall != DEPTH + 1 || idx != 2 * DEPTH)
            $display("FAIL b2b_stall: got stall=%0d accepted=%0d expected %0d %0d",
                     stall, idx, DEPTH + 1, 2 * DEPTH);
        else pass_cnt++;
        chk_cnt++;
        if (!ok || (out_cnt - base) != 2 * DEPTH)
            $display("FAIL b2b_count: got ready=%b words=%0d expected 1 %0d", ok, out_cnt - base, 2 * DEPTH);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        int base;
        bit ok;
        ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            data_i = 32'h20 + WIDTH'(i); valid_i = 1'b1;
            tick();
        end
        data_i = 32'h22;
        #1;
        chk_cnt++;
        if (mem_en_o !== 1'b1)
            $display("FAIL pre_reset_write: got en=%b expected 1", mem_en_o);
        else pass_cnt++;
        rst_i = 1'b1;
        #1;
        chk_cnt++;
        if ({valid_o, mem_en_o, mem_wr_en_o, last_o, ready_o} !== 5'b00001)
            $display("FAIL async_reset_fill: got %b expected 00001",
                     {valid_o, mem_en_o, mem_wr_en_o, last_o, ready_o});
        else pass_cnt++;
        valid_i = 1'b0;
        tick();
        rst_i = 1'b0;
        base = out_cnt;
        fill_frame(32'h30);
        wait_ready(ok);
        chk_cnt++;
        if (!ok || (out_cnt - base) != DEPTH)
            $display("FAIL mid_reset_count: got ready=%b words=%0d expected 1 %0d", ok, out_cnt - base, DEPTH);
        else pass_cnt++;
    endtask

    task automatic test_drain_reset();
        int base;
        bit ok;
        ready_i = 1'b0;
        fill_frame(32'h40);
        tick();
        #1;
        chk_cnt++;
        if ({valid_o, data_o} !== {1'b1, 32'h40})
            $display("FAIL drain_presented: got v=%b d=%h expected v=1 d=40", valid_o, data_o);
        else pass_cnt++;
        rst_i = 1'b1;
        #1;
        chk_cnt++;
        if ({valid_o, ready_o, last_o, mem_en_o} !== 4'b0100)
            $display("FAIL async_reset_drain: got %b expected 0100", {valid_o, ready_o, last_o, mem_en_o});
        else pass_cnt++;
        tick();
        rst_i = 1'b0;
        ready_i = 1'b1;
        base = out_cnt;
        fill_frame(32'h50);
        wait_ready(ok);
        chk_cnt++;
        if (!ok || (out_cnt - base) != DEPTH)
            $display("FAIL drain_reset_count: got ready=%b words=%0d expected 1 %0d", ok, out_cnt - base, DEPTH);
        else pass_cnt++;
    endtask

    initial begin
        rst_i   = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i  = '0;
        test_reset();
        test_fill_drain();
        test_backpressure();
        test_upstream_gaps();
        test_back_to_back();
        test_mid_reset();
        test_drain_reset();
        repeat (2) tick();
        chk_cnt++;
        if (exp_q.size() != 0)
            $display("FAIL sb_leftover: got %0d pending words expected 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/frame_buffer_ctrl.md
Name: frame_buffer_ctrl

Overview:
- Controller that sits directly in front of a single-port DFF RAM instance (WIDTH x DEPTH) and drives all of that RAM's ports.
- Collects a frame of exactly DEPTH words from an upstream valid/ready stream and writes them to addresses 0..DEPTH-1.
- Then plays the frame back in address order on a downstream valid/ready stream at full throughput, and asserts last_o on the final word.
- Alternates strictly between fill and drain, because the RAM has one port.

Parameters:
- WIDTH, 32, data word width; must match the attached RAM.
- DEPTH, 256, words per frame and RAM depth; power of two and at least 2.
- ADDR_BW (localparam), $clog2(DEPTH), RAM address width.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- data_i  input  WIDTH  upstream word.
- valid_i  input  1  upstream word valid.
- ready_o  output  1  controller accepts upstream word.
- data_o  output  WIDTH  downstream word.
- valid_o  output  1  downstream word valid.
- ready_i  input  1  downstream accepts word.
- last_o  output  1  high with valid_o on the final word of the frame (address DEPTH-1).
- mem_en_o  output  1  RAM enable.
- mem_wr_en_o  output  1  RAM write enable.
- mem_addr_o  output  ADDR_BW  RAM address.
- mem_data_o  output  WIDTH  RAM write data.
- mem_data_i  input  WIDTH  RAM registered read data; valid one cycle after an enabled access.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - state=FILL, wr_ptr=0, rd_ptr=0, rd_valid=0.
  - Outputs: ready_o=1, valid_o=0, last_o=0, mem_en_o=0, mem_wr_en_o=0.
  - A partial frame is discarded; RAM contents are not cleared.
- FILL state:
  - ready_o=1, valid_o=0.
  - On valid_i&&ready_o (combinational to the RAM): mem_en_o=1, mem_wr_en_o=1, mem_addr_o=wr_ptr, mem_data_o=data_i.
  - On that handshake, wr_ptr increments. If wr_ptr==DEPTH-1, wr_ptr wraps to 0 and state becomes DRAIN.
  - With no handshake: mem_en_o=0, mem_wr_en_o=0, no state change.
- DRAIN state:
  - ready_o=0; upstream is stalled for the entire drain.
  - mem_wr_en_o=0 always. mem_data_o is a don't-care; drive data_i.
  - Read issue condition: rd_ptr has not passed DEPTH-1 (reads remaining) AND (!valid_o || ready_i).
  - On issue: mem_en_o=1, mem_addr_o=rd_ptr, rd_ptr++; the rd_valid flag is set for the next cycle.
  - data_o = mem_data_i (combinational pass-through); valid_o = rd_valid.
  - The RAM holds read_data while mem_en_o=0, so data_o is stable under backpressure.
  - rd_valid clears on handshake (valid_o&&ready_i) when no new read issued the same cycle; stays set otherwise.
  - Issuing a read in the same cycle as a handshake is legal: the RAM output updates at the same edge that completes the handshake.
  - A read_count/issued flag tracks the final address so that no read is issued beyond DEPTH-1.
  - last_o = valid_o && (word being presented is address DEPTH-1).
  - On handshake with last_o=1: state becomes FILL, rd_ptr=0, rd_valid=0. ready_o is 1 in the following cycle.
- Latency and throughput:
  - The final FILL write in cycle T gives mem_en_o read of addr 0 in T+1 and valid_o=1 in T+2.
  - With ready_i held high, one word per cycle; a DEPTH-word drain takes DEPTH+1 cycles.
  - Fill runs at one word per cycle when valid_i is held high.
- Invariants:
  - mem_wr_en_o implies mem_en_o.
  - Never mem_wr_en_o in DRAIN.
  - Never valid_o in FILL.
  - mem_addr_o always < DEPTH.
- Simultaneous events: valid_i is ignored in DRAIN (ready_o=0); ready_i is ignored when valid_o=0.

Test Plan:
- Reset then fill: DEPTH=4, push 0xA,0xB,0xC,0xD with ready_i=1 -> writes at addr 0..3; data_o=0xA,0xB,0xC,0xD on 4 consecutive cycles starting 2 cycles after the last write; last_o only with 0xD; ready_o=1 the cycle after.
- Backpressure: same frame, ready_i=0 for 3 cycles while valid_o=1 on 0xB -> data_o holds 0xB, mem_en_o=0 during stall, no words lost or duplicated.
- Upstream gaps: valid_i toggling 1,0,1,0… -> writes only on handshake cycles, wr_ptr correct, frame content unchanged.
- Back-to-back frames: frame 1..4 then 5..8 with valid_i held high -> ready_o=0 throughout drain 1; second output is 5,6,7,8 with last_o on 8.
- Mid-frame reset: assert rst_i after 2 writes, then push 4 new words -> output equals only the 4 new words; valid_o, mem_en_o, and last_o are low immediately on rst_i assertion (asynchronous).
- Reset during drain with valid_o=1 -> valid_o=0 immediately, ready_o=1, next 4 pushes form a fresh frame.
